fetch_unit: RTL

- Instruction fetch stage directly upstream of the instruction decoder: owns the PC, drives a single-outstanding-request instruction-memory handshake and presents a buffered instruction plus its opcode/func fields to decode.
- Absorbs decode-side stalls through a 2-entry buffer (output register + skid) and handles branch/jump redirects via a flush/redirect input.

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// and buffers up to two fetched instructions (output + skid) for the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  func
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        out_v_q, out_v_d;
  logic [31:0] out_q, out_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        consume;
  logic        accept;
  logic        buf_full;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    out_v_d      = out_v_q;
    out_d        = out_q;
    out_pc_d     = out_pc_q;
    skid_v_d     = skid_v_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    consume      = out_v_q & ~stall;
    accept       = (state_q == ST_REQ) & imem_ready & ~flush;
    buf_full     = 1'b0;

    if (flush) begin
      out_v_d  = 1'b0;
      out_d    = '0;
      skid_v_d = 1'b0;
      skid_d   = '0;
      pc_d     = redirect_pc & ~32'd3;
      case (state_q)
        ST_REQ: begin
          // An unanswered request must still complete on the bus before the new PC is used
          if (imem_ready) begin
            state_d = ST_REQ;
          end else begin
            state_d      = ST_DRAIN;
            drain_addr_d = pc_q;
          end
        end
        ST_DRAIN: state_d = imem_ready ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      if (consume) begin
        if (skid_v_q) begin
          out_v_d  = 1'b1;
          out_d    = skid_q;
          out_pc_d = skid_pc_q;
          skid_v_d = accept;
          if (accept) begin
            skid_d    = imem_rdata;
            skid_pc_d = pc_q;
          end
        end else begin
          out_v_d = accept;
          out_d   = accept ? imem_rdata : 32'h0;
          if (accept) out_pc_d = pc_q;
        end
      end else if (!out_v_q) begin
        if (accept) begin
          out_v_d  = 1'b1;
          out_d    = imem_rdata;
          out_pc_d = pc_q;
        end
      end else if (accept) begin
        skid_v_d  = 1'b1;
        skid_d    = imem_rdata;
        skid_pc_d = pc_q;
      end

      if (accept) pc_d = pc_q + 32'd4;
      buf_full = out_v_d & skid_v_d;

      case (state_q)
        ST_IDLE:  state_d = buf_full ? ST_IDLE : ST_REQ;
        ST_REQ:   if (imem_ready) state_d = buf_full ? ST_IDLE : ST_REQ;
        ST_DRAIN: if (imem_ready) state_d = ST_REQ;
        default:  state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC & ~32'd3;
      drain_addr_q <= '0;
      out_v_q      <= 1'b0;
      out_q        <= '0;
      out_pc_q     <= '0;
      skid_v_q     <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      out_v_q      <= out_v_d;
      out_q        <= out_d;
      out_pc_q     <= out_pc_d;
      skid_v_q     <= skid_v_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem_req    = ~reset & ((state_q == ST_REQ) | (state_q == ST_DRAIN));
  assign imem_addr   = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign instr_valid = out_v_q;
  assign instr       = out_v_q ? out_q : 32'h0;
  assign instr_pc    = out_pc_q;
  assign opcode      = instr[31:26];
  assign func        = instr[5:0];

endmodule
